// File: rtl/fetch_sequencer.sv
// Program-fetch controller: owns the PC, reads the instruction ROM and issues one registered instruction per cycle.
// Latency: first instruction valid 2 edges after start/redirect; backpressure: instr_valid && !instr_ready holds pc/instr/instr_pc.
module fetch_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_q,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              issue;
    logic              vld_clr;

    assign imem_addr = pc;
    assign busy      = (state == RUN);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        issue     = 1'b0;
        vld_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (redirect) pc_nxt = redirect_pc;
                if (start)    state_nxt = RUN;
            end
            RUN: begin
                // Redirect wins over any load and flushes the output slot.
                if (redirect) begin
                    pc_nxt  = redirect_pc;
                    vld_clr = 1'b1;
                end else if (!instr_valid || instr_ready) begin
                    if (imem_q == HALT_WORD) begin
                        state_nxt = HALT;
                        vld_clr   = 1'b1;
                    end else begin
                        issue  = 1'b1;
                        pc_nxt = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= (state_nxt == HALT);
            if (issue) begin
                instr       <= imem_q;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (vld_clr) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
